// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, selects the next address, runs the
// instruction-memory request/ack handshake, and handles stall, exception, eret and misaligned traps.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] branch_off,
    input  logic [25:0]      jump_idx,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc,
    input  logic             eret,
    input  logic             fetch_ack,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             fetch_req,
    output logic             addr_err
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] next_pc;
    logic             advance;

    assign pc_plus4 = pc_q + WIDTH'(4);

    // Next-address source mux
    always_comb begin
        next_pc = pc_plus4;
        unique case (sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + (branch_off << 2);
            2'b10: next_pc = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00};
            2'b11: next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

    assign advance = ((state_q == ST_REQ) && fetch_ack && !stall) ||
                     ((state_q == ST_HOLD) && !stall);

    // Handshake FSM with redirect priority: exc, then misaligned trap, then eret
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        addr_err = 1'b0;

        unique case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ:  if (fetch_ack && stall) state_d = ST_HOLD;
            ST_HOLD: if (!stall) state_d = ST_REQ;
            default: state_d = ST_BOOT;
        endcase

        if (advance) begin
            pc_d = next_pc;
        end

        if (exc) begin
            pc_d    = EXC_VECTOR;
            epc_d   = pc_q;
            state_d = ST_REQ;
        end else if (advance && (next_pc[1:0] != 2'b00)) begin
            pc_d     = EXC_VECTOR;
            epc_d    = next_pc;
            addr_err = 1'b1;
            state_d  = ST_REQ;
        end else if (eret) begin
            pc_d    = epc_q;
            state_d = ST_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign fetch_req = (state_q == ST_REQ);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences for reset,
// and randomized traffic checked against a behavioural model.
module tb_pc_unit;

    localparam logic [31:0] EXC_V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] branch_off = '0;
    logic [25:0] jump_idx = '0;
    logic [31:0] jr_target = '0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic        fetch_ack = 1'b0;
    logic [31:0] pc, pc_plus4, epc;
    logic        fetch_req, addr_err;

    int n_pass = 0;
    int n_total = 0;

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .sel(sel), .branch_off(branch_off),
        .jump_idx(jump_idx), .jr_target(jr_target), .exc(exc), .eret(eret),
        .fetch_ack(fetch_ack), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
        .fetch_req(fetch_req), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] jr;
        logic        exc;
        logic        eret;
        logic        ack;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_epc;
        logic        e_aerr;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: architectural pc/epc plus "booting" and "waiting for stall to drop" flags
    logic [31:0] m_pc, m_epc;
    bit          m_boot, m_wait;
    logic [31:0] n_pc, n_epc;
    bit          n_wait, m_aerr;

    function automatic vec_t mk(logic st, logic [1:0] s, logic [31:0] o, logic [25:0] ix,
                                logic [31:0] j, logic ex, logic er, logic ak,
                                logic [31:0] ep, logic erq, logic [31:0] ee, logic ea);
        vec_t v;
        v.stall = st; v.sel = s; v.off = o; v.idx = ix; v.jr = j; v.exc = ex; v.eret = er;
        v.ack = ak; v.e_pc = ep; v.e_req = erq; v.e_epc = ee; v.e_aerr = ea;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_eval();
        logic [31:0] target;
        bit          requesting, adv;
        case (sel)
            2'b00:   target = m_pc + 32'd4;
            2'b01:   target = m_pc + 32'd4 + branch_off * 32'd4;
            2'b10:   target = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_idx) * 32'd4);
            default: target = jr_target;
        endcase
        requesting = !m_boot && !m_wait;
        adv = (requesting && fetch_ack && !stall) || (m_wait && !stall);
        n_pc = adv ? target : m_pc;
        n_epc = m_epc;
        n_wait = m_wait ? stall : (requesting && fetch_ack && stall);
        m_aerr = 1'b0;
        if (exc) begin
            n_pc = EXC_V; n_epc = m_pc; n_wait = 1'b0;
        end else if (adv && (target % 4 != 0)) begin
            n_pc = EXC_V; n_epc = target; n_wait = 1'b0; m_aerr = 1'b1;
        end else if (eret) begin
            n_pc = m_epc; n_wait = 1'b0;
        end
    endtask

    task automatic model_check(string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_epc"}, epc, m_epc);
        chk({tag, "_req"}, 32'(fetch_req), 32'(!m_boot && !m_wait));
        chk({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
    endtask

    // One clock: drive at posedge+1, check addr_err mid-cycle, check state after the edge
    task automatic step(logic st, logic [1:0] s, logic [31:0] o, logic [25:0] ix,
                        logic [31:0] j, logic ex, logic er, logic ak, string tag);
        stall = st; sel = s; branch_off = o; jump_idx = ix; jr_target = j;
        exc = ex; eret = er; fetch_ack = ak;
        #2;
        model_eval();
        chk({tag, "_aerr"}, 32'(addr_err), 32'(m_aerr));
        @(posedge clk);
        #1;
        m_pc = n_pc; m_epc = n_epc; m_wait = n_wait; m_boot = 1'b0;
        model_check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; sel = 2'b00; exc = 1'b0; eret = 1'b0; fetch_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pc = 32'h0; m_epc = 32'h0; m_boot = 1'b1; m_wait = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_req", 32'(fetch_req), 32'h0);
        chk("rst_aerr", 32'(addr_err), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(fetch_req), 32'h0);
    endtask

    initial begin
        // stall sel off idx jr exc eret ack | pc req epc aerr
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h8, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h40, 0, 0, 1, 32'h40, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 32'h0, 0));
        tbl.push_back(mk(1, 2'd0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 32'h0, 0));
        tbl.push_back(mk(1, 2'd0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 0));
        tbl.push_back(mk(1, 2'd0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 32'h44, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, 32'hFC, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h1000_0000, 0, 0, 1, 32'h1000_0000, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd2, 0, 26'h10, 0, 0, 0, 1, 32'h1000_0040, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h200, 0, 0, 1, 32'h200, 1, 32'h0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 1, 0, 0, EXC_V, 1, 32'h200, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h8000_0184, 1, 32'h200, 0));
        tbl.push_back(mk(1, 2'd0, 0, 0, 0, 0, 1, 0, 32'h200, 1, 32'h200, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h204, 1, 32'h200, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 0, EXC_V, 1, 32'h204, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h303, 0, 0, 1, EXC_V, 1, 32'h303, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, EXC_V, 1, 32'h303, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'h303, 1, 0, 1, EXC_V, 1, EXC_V, 0));
        tbl.push_back(mk(0, 2'd3, 0, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 1, EXC_V, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h0, 1, EXC_V, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h4, 1, EXC_V, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h8, 1, EXC_V, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            stall = v.stall; sel = v.sel; branch_off = v.off; jump_idx = v.idx;
            jr_target = v.jr; exc = v.exc; eret = v.eret; fetch_ack = v.ack;
            #2;
            chk($sformatf("vec%0d_aerr", i), 32'(addr_err), 32'(v.e_aerr));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", i), pc, v.e_pc);
            chk($sformatf("vec%0d_req", i), 32'(fetch_req), 32'(v.e_req));
            chk($sformatf("vec%0d_epc", i), epc, v.e_epc);
        end

        // Reset asserted mid-request takes effect without a clock edge
        fetch_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(fetch_req), 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_epc", epc, 32'h0);

        // Randomized traffic against the model
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] j;
            j = $urandom;
            if ($urandom_range(0, 9) != 0) j = j & 32'hFFFF_FFFC;
            step(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                 32'($signed(16'($urandom))), 26'($urandom), j,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 6), "rnd");
            if (n_total - n_pass > 20) break;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS datapath, replacing the bare PC register. It holds the fetch address, computes the next address (sequential, branch, jump, jump-register), and runs a request/acknowledge handshake with instruction memory. It also handles pipeline stalls, exception redirect with EPC capture, exception return, and misaligned-target trapping. It sits between the control/branch logic of decode and the instruction-memory port.

## Interface
- WIDTH, 32, address width; must be ≥ 29.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC value loaded on exception.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  pipeline stall; blocks PC advance.
- sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- branch_off  in  WIDTH  sign-extended word offset.
- jump_idx  in  26  J-type instruction index.
- jr_target  in  WIDTH  register-sourced target.
- exc  in  1  exception request.
- eret  in  1  exception return.
- fetch_ack  in  1  instruction memory accepted the current pc.
- pc  out  WIDTH  current fetch address.
- pc_plus4  out  WIDTH  pc + 4, combinational.
- epc  out  WIDTH  exception PC register.
- fetch_req  out  1  fetch request for pc.
- addr_err  out  1  one-cycle pulse on a misaligned computed target.

## Operation
- next-PC computation, all arithmetic modulo 2^WIDTH:
  - seq = pc + 4.
  - branch = pc + 4 + (branch_off << 2).
  - jump = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00}.
  - jr = jr_target.
- FSM states BOOT, REQ, HOLD:
  - BOOT: fetch_req = 0. Always goes to REQ on the next edge.
  - REQ: fetch_req = 1 and pc is held stable until acknowledged.
    - fetch_ack & !stall: pc <= next; stay in REQ.
    - fetch_ack & stall: go to HOLD; pc unchanged.
    - !fetch_ack: stay in REQ; pc unchanged; stall is ignored.
  - HOLD: fetch_req = 0. When !stall: pc <= next (sel sampled this cycle), go to REQ.
- Redirect events, allowed in any state, highest priority first:
  - exc: pc <= EXC_VECTOR; epc <= pc; go to REQ. An outstanding request is abandoned.
  - eret: pc <= epc; go to REQ.
  - exc and eret in the same cycle: exc wins; epc <= pc.
  - stall never blocks a redirect.
- Misaligned target (advance with next[1:0] ≠ 0, reachable only via jr):
  - pc <= EXC_VECTOR; epc <= the offending target; addr_err = 1 for that cycle.
  - Only an external exc in the same cycle overrides it, and then addr_err = 0.
- epc changes only on exc or on a misaligned trap.

## Timing
- Reset (rst_n low, asynchronous): pc = RESET_VECTOR, epc = 0, state = BOOT, fetch_req = 0, addr_err = 0.
- First fetch_req = 1 appears one cycle after rst_n deasserts (the BOOT cycle).
- Redirect latency:
  - exc/eret sampled at edge N: pc = new value after edge N.
  - fetch_req = 1 in the cycle after edge N.
- Advance latency: one edge after fetch_ack & !stall. Back-to-back acks give one address per cycle.
- addr_err is combinational on the advancing cycle and is asserted only when the trap is actually taken.
- rst_n asserted mid-request aborts it immediately; fetch_req drops asynchronously.
- Wrap-around: pc = 32'hFFFF_FFFC, sequential advance gives 0. No trap is raised.

## Test plan
- Reset/boot:
  - Release rst_n.
  - Required: pc = 0, fetch_req = 0 for one cycle, then 1.
  - ack each cycle with sel = 00: pc steps 0, 4, 8, C.
- Handshake hold:
  - pc = 0x40, fetch_ack low for 3 cycles.
  - Required: pc stays 0x40 and fetch_req stays 1.
  - ack with stall = 1: pc = 0x40 and fetch_req = 0 while stalled.
  - stall drops: pc = 0x44, fetch_req returns to 1.
- Branch/jump arithmetic (fresh run for each case):
  - pc = 0x100, sel = 01, branch_off = 0xFFFF_FFFE, ack: pc = 0xFC.
  - pc = 0x1000_0000, sel = 10, jump_idx = 0x10, ack: pc = 0x1000_0040.
- Exception and return:
  - pc = 0x200, exc during an un-acked request: pc = 0x8000_0180, epc = 0x200.
  - Later eret: pc = 0x200.
  - exc and eret in the same cycle: exc wins.
- Misaligned jr:
  - sel = 11, jr_target = 0x303, ack.
  - Required: addr_err pulses for one cycle, pc = 0x8000_0180, epc = 0x303.
- Wrap and mid-operation reset:
  - pc = 0xFFFF_FFFC, sequential ack: pc = 0, addr_err = 0.
  - Assert rst_n low mid-REQ: fetch_req = 0 and pc = 0 immediately.
